// File: rtl/dds_pkg.sv
// Shared definitions for the DDS receive path: mid-scale level and demodulator states.
// No logic; constants and types only.
// Imported by xing_detect and fsk_demod.
package dds_pkg;

   // Offset-binary mid-scale; also the transmitter's constant "carrier off" level.
   localparam logic [7:0] MIDSCALE = 8'd128;

   // Demodulator lock states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } demod_state_t;

endpackage

// File: rtl/xing_detect.sv
// Registers the ADC sample and slices it at mid-scale with hysteresis; emits a rising-crossing strobe.
// Latency: sample captured at edge k -> comp and rise update at edge k+1.
// No backpressure: one sample accepted every cycle.
module xing_detect
   import dds_pkg::*;
#(
   parameter int HYST = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] adc,
   output logic       rise
);

   // Thresholds kept 9 bits wide so 128+HYST cannot wrap for any sane HYST (< 128).
   localparam logic [8:0] HI_TH = 9'(int'(MIDSCALE) + HYST);
   localparam logic [8:0] LO_TH = 9'(int'(MIDSCALE) - 1 - HYST);

   logic [7:0] adc_q;
   logic       comp;
   logic       comp_nxt;

   // Hysteresis slicer: switch only when the sample clears the far threshold.
   always_comb begin
      comp_nxt = comp;
      if (!comp && ({1'b0, adc_q} >= HI_TH)) begin
         comp_nxt = 1'b1;
      end else if (comp && ({1'b0, adc_q} <= LO_TH)) begin
         comp_nxt = 1'b0;
      end
   end

   // Sample register, comparator state and registered 0->1 strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_q <= MIDSCALE;
         comp  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         adc_q <= adc;
         comp  <= comp_nxt;
         rise  <= comp_nxt & ~comp;
      end
   end

endmodule

// File: rtl/fsk_demod.sv
// FSK/OOK demodulator: measures carrier period between rising crossings and decides the data bit.
// Latency: crossing sample captured at edge k -> period/carrier/rf_data update at edge k+2.
// No backpressure: period_valid is a fire-and-forget strobe, never on consecutive cycles.
module fsk_demod
   import dds_pkg::*;
#(
   parameter int HYST       = 8,
   parameter int PER_W      = 16,
   parameter int MAX_PERIOD = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       adc,
   input  logic             ook_mode,
   input  logic [PER_W-1:0] period_thresh,
   output logic [PER_W-1:0] period_out,
   output logic             period_valid,
   output logic             carrier,
   output logic             rf_data
);

   localparam logic [PER_W-1:0] CNT_SAT     = '1;
   localparam logic [PER_W-1:0] TIMEOUT_CNT = PER_W'(MAX_PERIOD);

   logic             rise;
   logic [PER_W-1:0] cnt;
   logic             timeout;
   logic             drop;

   demod_state_t     state;
   demod_state_t     state_nxt;

   logic [PER_W-1:0] per_nxt;
   logic             pv_nxt;
   logic             car_nxt;
   logic             rf_nxt;

   xing_detect #(
      .HYST (HYST)
   ) u_xing (
      .clk  (clk),
      .rst  (rst),
      .adc  (adc),
      .rise (rise)
   );

   // A crossing in the timeout cycle wins: the carrier is still there.
   assign timeout = (cnt == TIMEOUT_CNT) && !rise;
   assign drop    = (state != IDLE) && timeout;

   // Period counter: restarts at 1 on each crossing so its value at the next crossing is the period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= {{(PER_W-1){1'b0}}, 1'b1};
      end else if (cnt != CNT_SAT) begin
         cnt <= cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: first crossing arms, second locks, a silent MAX_PERIOD window drops lock.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rise) state_nxt = ACQ;
         end
         ACQ: begin
            if (rise)         state_nxt = TRACK;
            else if (timeout) state_nxt = IDLE;
         end
         TRACK: begin
            if (timeout) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: next values of the registered outputs.
   always_comb begin
      per_nxt = period_out;
      pv_nxt  = 1'b0;
      car_nxt = carrier;
      rf_nxt  = rf_data;

      if ((state == ACQ || state == TRACK) && rise) begin
         per_nxt = cnt;
         pv_nxt  = 1'b1;
         car_nxt = 1'b1;
      end else if (drop) begin
         car_nxt = 1'b0;
      end

      // Mode is sampled every cycle so a switch takes effect at the next register update.
      if (drop) begin
         rf_nxt = 1'b0;
      end else if (ook_mode) begin
         rf_nxt = car_nxt;
      end else if (pv_nxt) begin
         // Shorter period (higher tone) decodes as 1; equality decodes as 0.
         rf_nxt = (cnt < period_thresh);
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_out   <= '0;
         period_valid <= 1'b0;
         carrier      <= 1'b0;
         rf_data      <= 1'b0;
      end else begin
         period_out   <= per_nxt;
         period_valid <= pv_nxt;
         carrier      <= car_nxt;
         rf_data      <= rf_nxt;
      end
   end

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: square-wave vector table plus sine, OOK, reset and saturation sequences.
module tb_fsk_demod;
   import dds_pkg::*;

   logic        clk;
   logic        rst;
   logic [7:0]  adc;
   logic        ook_mode;
   logic [15:0] period_thresh;
   logic [15:0] period_out;
   logic        period_valid;
   logic        carrier;
   logic        rf_data;

   int n_cmp = 0;
   int n_bad = 0;

   // observation state updated once per cycle
   int          pv_cnt;
   int          consec;
   bit          prev_pv;
   logic [15:0] last_per;
   logic        last_rf;
   int          per_q[$];
   bit          rf_q[$];
   logic [15:0] phase;

   typedef struct {
      int          per;
      int          k;
      logic [15:0] thresh;
      bit          ook;
      logic [15:0] exp_per;
      bit          exp_rf;
      int          exp_pv;
   } vec_t;

   vec_t tbl[10];

   fsk_demod #(
      .HYST       (8),
      .PER_W      (16),
      .MAX_PERIOD (1024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .adc           (adc),
      .ook_mode      (ook_mode),
      .period_thresh (period_thresh),
      .period_out    (period_out),
      .period_valid  (period_valid),
      .carrier       (carrier),
      .rf_data       (rf_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      pv_cnt  = 0;
      consec  = 0;
      prev_pv = 1'b0;
      last_per = '0;
      last_rf  = 1'b0;
      per_q.delete();
      rf_q.delete();
   endtask

   // advance one edge, sample outputs 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
      if (period_valid === 1'b1) begin
         pv_cnt++;
         if (prev_pv) consec++;
         last_per = period_out;
         last_rf  = rf_data;
         per_q.push_back(int'(period_out));
         rf_q.push_back(rf_data);
      end
      prev_pv = (period_valid === 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      adc = 8'd128;
      ook_mode = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      clear_stats();
   endtask

   function automatic logic [7:0] sine_at(input logic [15:0] ph);
      real a;
      int  v;
      a = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
      v = $rtoi($floor(127.0 * $sin(a) + 0.5)) + 128;
      return 8'(v);
   endfunction

   task automatic run_dds(input logic [15:0] tw, input int n);
      for (int i = 0; i < n; i++) begin
         adc = sine_at(phase);
         tick();
         phase = phase + tw;
      end
   endtask

   // k periods of a square wave, then a few mid-scale cycles to drain the pipeline
   task automatic run_square(input int per, input int k);
      for (int r = 0; r < k; r++) begin
         for (int j = 0; j < per; j++) begin
            adc = (j < per / 2) ? 8'd200 : 8'd56;
            tick();
         end
      end
      adc = 8'd128;
      repeat (4) tick();
   endtask

   initial begin
      int exp_p[7];
      bit exp_r[7];

      //          per   k  thresh ook exp_per rf  pv
      tbl[0] = '{  64,  6, 16'd48, 0, 16'd64,  0,  5};
      tbl[1] = '{  32,  6, 16'd48, 0, 16'd32,  1,  5};
      tbl[2] = '{  48,  6, 16'd48, 0, 16'd48,  0,  5};
      tbl[3] = '{  48,  6, 16'd49, 0, 16'd48,  1,  5};
      tbl[4] = '{  47,  6, 16'd48, 0, 16'd47,  1,  5};
      tbl[5] = '{   2,  6, 16'd3,  0, 16'd2,   1,  5};
      tbl[6] = '{   2,  6, 16'd2,  0, 16'd2,   0,  5};
      tbl[7] = '{  64,  6, 16'd0,  1, 16'd64,  1,  5};
      tbl[8] = '{1000,  3, 16'd48, 0, 16'd1000, 0, 2};
      tbl[9] = '{  32,  4, 16'd0,  1, 16'd32,  1,  3};

      rst = 1'b1;
      adc = 8'd128;
      ook_mode = 1'b0;
      period_thresh = 16'd48;
      phase = '0;
      clear_stats();

      // reset state
      tick();
      check("rst_period_out", period_out, 0);
      check("rst_period_valid", period_valid, 0);
      check("rst_carrier", carrier, 0);
      check("rst_rf_data", rf_data, 0);

      // table of square-wave vectors
      foreach (tbl[v]) begin
         do_reset();
         period_thresh = tbl[v].thresh;
         ook_mode = tbl[v].ook;
         run_square(tbl[v].per, tbl[v].k);
         check($sformatf("vec%0d_pv_count", v), pv_cnt, tbl[v].exp_pv);
         check($sformatf("vec%0d_period", v), last_per, tbl[v].exp_per);
         check($sformatf("vec%0d_rf", v), last_rf, tbl[v].exp_rf);
         check($sformatf("vec%0d_carrier", v), carrier, 1);
         check($sformatf("vec%0d_consecutive_pv", v), consec, 0);
      end

      // FSK with DDS sine, tone switch at a phase wrap
      do_reset();
      period_thresh = 16'd48;
      phase = '0;
      run_dds(16'h0400, 256);
      run_dds(16'h0800, 128);
      exp_p = '{64, 64, 64, 64, 32, 32, 32};
      exp_r = '{0, 0, 0, 0, 1, 1, 1};
      check("fsk_pv_count", per_q.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < per_q.size()) begin
            check($sformatf("fsk_period_%0d", i), per_q[i], exp_p[i]);
            check($sformatf("fsk_rf_%0d", i), rf_q[i], exp_r[i]);
         end
      end

      // hysteresis: swing inside the dead band never toggles the comparator
      do_reset();
      for (int i = 0; i < 200; i++) begin
         adc = (i % 2 == 0) ? 8'd124 : 8'd132;
         tick();
      end
      check("hyst_pv_count", pv_cnt, 0);
      check("hyst_carrier", carrier, 0);

      // OOK burst: lock two cycles after the second crossing, drop 1024+2 after the last
      do_reset();
      ook_mode = 1'b1;
      period_thresh = 16'd0;
      phase = '0;
      for (int i = 0; i < 1130; i++) begin
         adc = (i < 128) ? sine_at(phase) : 8'd128;
         phase = phase + 16'h0800;
         tick();
         if (i == 34) begin
            check("ook_carrier_before_lock", carrier, 0);
            check("ook_rf_before_lock", rf_data, 0);
         end
         if (i == 35) begin
            check("ook_carrier_lock", carrier, 1);
            check("ook_rf_lock", rf_data, 1);
         end
         if (i == 1122) begin
            check("ook_carrier_before_drop", carrier, 1);
            check("ook_rf_before_drop", rf_data, 1);
         end
         if (i == 1123) begin
            check("ook_carrier_drop", carrier, 0);
            check("ook_rf_drop", rf_data, 0);
         end
      end

      // reset mid-stream, then two fresh crossings needed for the next strobe
      do_reset();
      period_thresh = 16'd48;
      run_square(32, 4);
      check("midrst_carrier_pre", carrier, 1);
      check("midrst_rf_pre", rf_data, 1);
      check("midrst_period_pre", period_out, 32);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_period_out", period_out, 0);
      check("midrst_period_valid", period_valid, 0);
      check("midrst_carrier", carrier, 0);
      check("midrst_rf_data", rf_data, 0);
      tick();
      rst = 1'b0;
      clear_stats();
      run_square(32, 2);
      check("midrst_pv_count", pv_cnt, 1);
      check("midrst_period_after", last_per, 32);

      // saturation: a single crossing, then a stuck-high input
      do_reset();
      adc = 8'd200;
      repeat (70000) tick();
      check("sat_pv_count", pv_cnt, 0);
      check("sat_cnt", dut.cnt, 16'hFFFF);
      check("sat_state", int'(dut.state), int'(IDLE));
      check("sat_carrier", carrier, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
